// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO PUF datapath.
// Contents: RO count / index width constants, vector and index types,
// and the state encoding of the select encoder.
package ro_puf_pkg;

    localparam int unsigned RO_COUNT = 16;
    localparam int unsigned RO_IDX_W = 4;

    typedef logic [RO_COUNT-1:0] ro_vec_t;
    typedef logic [RO_IDX_W-1:0] ro_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

endpackage : ro_puf_pkg

// File: rtl/ro_sel_encoder_if.sv
// Handshake bundle between flag logic, ro_sel_encoder and the serial consumer.
// Input side : in_valid / in_ready / in_vec
// Output side: out_valid / out_ready / out_idx / out_last, plus err_zero pulse.
// master = producer/consumer environment, slave = the encoder.
interface ro_sel_encoder_if
    import ro_puf_pkg::*;
();

    logic    in_valid;
    logic    in_ready;
    ro_vec_t in_vec;
    logic    out_valid;
    logic    out_ready;
    ro_idx_t out_idx;
    logic    out_last;
    logic    err_zero;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, err_zero
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, err_zero
    );

endinterface : ro_sel_encoder_if

// File: rtl/ro_lsb_find16.sv
// Combinational lowest-set-bit finder over a 16-bit vector.
// Ports: vec    - vector to search
//        idx    - index of the lowest set bit (0 when vec is zero)
//        any    - at least one bit set
//        single - exactly one bit set
module ro_lsb_find16
    import ro_puf_pkg::*;
(
    input  ro_vec_t vec,
    output ro_idx_t idx,
    output logic    any,
    output logic    single
);

    ro_vec_t w_vec_m1;

    // Scan high to low so the last hit is the lowest set bit.
    always_comb begin
        idx = '0;
        for (int i = int'(RO_COUNT) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = RO_IDX_W'(i);
            end
        end
    end

    // vec & (vec-1) strips the lowest set bit; zero result means one-hot.
    assign w_vec_m1 = vec - ro_vec_t'(1);
    assign any      = |vec;
    assign single   = any && ((vec & w_vec_m1) == '0);

endmodule : ro_lsb_find16

// File: rtl/ro_sel_encoder.sv
// Sequential 16-to-4 encoder: reports the index of every set bit of an
// accepted vector, lowest first, one index per output handshake.
// Ports: clk - rising-edge clock
//        rst - synchronous active-high reset
//        bus - ro_sel_encoder_if.slave (input vector handshake, index
//              output handshake with out_last, err_zero pulse)
module ro_sel_encoder
    import ro_puf_pkg::*;
#(
    parameter int unsigned WIDTH = RO_COUNT,
    parameter int unsigned IDX_W = RO_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    ro_sel_encoder_if.slave   bus
);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             w_hs;
    logic             w_err_nxt;

    logic [IDX_W-1:0] w_nxt_idx;
    logic             w_nxt_any;
    logic             w_nxt_single;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_err_zero;

    assign w_hs = r_out_valid & bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next pending vector and zero-vector error.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_vec != '0) begin
                        w_pend_nxt  = bus.in_vec;
                        w_state_nxt = EMIT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (w_hs) begin
                    // Drop the bit just reported (always the lowest one).
                    w_pend_nxt = r_pend & (r_pend - WIDTH'(1));
                    if (r_out_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    // Output fields are precomputed from the next pending vector so they
    // come straight from flops.
    ro_lsb_find16 u_find (
        .vec    (w_pend_nxt),
        .idx    (w_nxt_idx),
        .any    (w_nxt_any),
        .single (w_nxt_single)
    );

    // Pending vector and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_err_zero  <= 1'b0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= w_nxt_any;
            r_out_idx   <= w_nxt_idx;
            r_out_last  <= w_nxt_single;
            r_err_zero  <= w_err_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.err_zero  = r_err_zero;

endmodule : ro_sel_encoder
